// File: rtl/display_scan_ctrl.sv
// Multiplexed seven-segment scan controller: BLANK/DWELL slot sequencer with
// brightness-scaled anode duty and a double-buffered frame register.
module display_scan_ctrl #(
    parameter int NDIGITS      = 2,
    parameter int DWELL_CYCLES = 2048,
    parameter int BLANK_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [4*NDIGITS-1:0]       load_data,
    input  logic [2:0]                 brightness,
    output logic [3:0]                 digit,
    output logic [NDIGITS-1:0]         anode,
    output logic [$clog2(NDIGITS)-1:0] scan_idx,
    output logic                       frame_done
);
    localparam int IW   = $clog2(NDIGITS);
    localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int UNIT = DWELL_CYCLES / 8;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NDIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DWELL = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [2:0]           bright_q, bright_d;
    logic [4*NDIGITS-1:0] pending_q, pending_d;
    logic [4*NDIGITS-1:0] active_q, active_d;
    logic                 pending_full_q, pending_full_d;
    logic                 boundary;
    logic                 dwell_lit;
    logic [CW-1:0]        lit_len;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_BLANK;
            cnt_q          <= '0;
            idx_q          <= '0;
            bright_q       <= '0;
            pending_q      <= '0;
            active_q       <= '0;
            pending_full_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            bright_q       <= bright_d;
            pending_q      <= pending_d;
            active_q       <= active_d;
            pending_full_q <= pending_full_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_DWELL;
                    cnt_d   = '0;
                end
            end
            ST_DWELL: begin
                if (cnt_q == DWELL_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase

        // Promotion only happens when pending is full, which also holds
        // load_ready low, so it can never collide with a new transfer.
        boundary       = (state_q == ST_BLANK) && (cnt_q == '0) && (idx_q == '0);
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        active_d       = active_q;
        if (boundary && pending_full_q) begin
            active_d       = pending_q;
            pending_full_d = 1'b0;
        end else if (load_valid && !pending_full_q) begin
            pending_d      = load_data;
            pending_full_d = 1'b1;
        end

        bright_d = ((state_q == ST_DWELL) && (cnt_q == '0)) ? brightness : bright_q;
    end

    // The first dwell cycle is lit at every brightness, so the live input is
    // never needed combinationally; later cycles use the captured level.
    always_comb begin
        lit_len    = CW'((32'(bright_q) + 32'd1) * UNIT);
        dwell_lit  = (state_q == ST_DWELL) && ((cnt_q == '0) || (cnt_q < lit_len));
        frame_done = (state_q == ST_DWELL) && (cnt_q == DWELL_LAST) && (idx_q == IDX_LAST);
        digit      = active_q[{idx_q, 2'b00} +: 4];
        scan_idx   = idx_q;
        load_ready = !pending_full_q;
    end

    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_anode
        assign anode[gi] = dwell_lit && (idx_q == IW'(gi));
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter NDIGITS, 2, number of multiplexed seven-segment digits (2..8).
REQ-002 Parameter DWELL_CYCLES, 2048, clk cycles per digit lit window; SHALL be a multiple of 8 and at least 8.
REQ-003 Parameter BLANK_CYCLES, 64, anti-ghosting guard cycles before each dwell, with all anodes off; at least 1.
REQ-004 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port load_valid  input  1  requester offers a new frame of digit values.
REQ-007 Port load_ready  output  1  block can accept a frame; a transfer occurs when load_valid and load_ready are both high on a clk edge.
REQ-008 Port load_data  input  4*NDIGITS  digit i nibble = load_data[4i+3:4i].
REQ-009 Port brightness  input  3  duty level 0..7.
REQ-010 Port digit  output  4  nibble of the currently scanned digit, for the seven-segment decoder.
REQ-011 Port anode  output  NDIGITS  one-hot, active-high digit enable; all zeros = blanked.
REQ-012 Port scan_idx  output  clog2(NDIGITS)  index of the currently scanned digit.
REQ-013 Port frame_done  output  1  one-cycle pulse at the end of each full scan.

Function
REQ-014 The FSM SHALL have two states: BLANK (BLANK_CYCLES long) and DWELL (DWELL_CYCLES long). It SHALL follow BLANK -> DWELL -> BLANK (scan_idx+1, wrapping NDIGITS-1 -> 0).
REQ-015 The frame length SHALL be exactly NDIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles, with no idle cycles.
REQ-016 Throughout BLANK and DWELL of slot i, digit SHALL equal active register nibble i.
REQ-017 anode SHALL be 0 for the whole of BLANK.
REQ-018 In DWELL, anode[scan_idx] SHALL be 1 for the first (b+1)*(DWELL_CYCLES/8) cycles and 0 for the remainder.
REQ-019 The value b in REQ-018 SHALL be brightness sampled on the first DWELL cycle; changes mid-dwell SHALL have no effect until the next dwell.
REQ-020 frame_done SHALL be 1 only on the last DWELL cycle of scan_idx NDIGITS-1.
REQ-021 Buffering: one pending register and one active register. load_ready SHALL equal NOT pending_full.
REQ-022 On an accepted transfer, load_data SHALL be written to pending and pending_full set; load_ready SHALL be low from the next cycle.
REQ-023 Frame boundary = first BLANK cycle of scan_idx 0. If pending_full is set at the start of that cycle, pending SHALL move to active and pending_full SHALL clear. load_ready SHALL be high the following cycle, and the new nibbles SHALL drive digit from that cycle on.
REQ-024 A transfer accepted on the frame-boundary cycle itself SHALL NOT be promoted until the next frame boundary.
REQ-025 load_valid while load_ready=0 SHALL be ignored; pending SHALL be unchanged and nothing SHALL be lost or overwritten.
REQ-026 Digit values SHALL never change mid-frame; the active register SHALL change only at a frame boundary.
REQ-027 Counters SHALL wrap without any glitch cycle: anode SHALL never have more than one bit set, including on state-transition cycles.

Reset
REQ-028 While reset=1, at each edge: anode=0, digit=0, scan_idx=0, frame_done=0, load_ready=1, active=0, pending cleared, state=BLANK, counter=0.
REQ-029 Reset asserted mid-operation SHALL take effect on the next edge, discarding pending data and the partial frame.
REQ-030 The first cycle after reset deasserts SHALL be a frame boundary (cycle 0). The first anode assertion SHALL occur at cycle BLANK_CYCLES.

Verification (NDIGITS=2, DWELL_CYCLES=16, BLANK_CYCLES=2; cycle 0 = first cycle after reset)
REQ-031 Scenario 1: reset, then load_valid=1 with load_data=8'h3A at cycle 0, brightness=7.
  - Accepted at cycle 0; load_ready=0 from cycle 1.
  - digit=0 during frame 0; anode=01 for cycles 2-17 and anode=10 for cycles 20-35.
  - At cycle 36 promotion occurs; digit=A from cycle 37; load_ready=1 at cycle 37.
REQ-032 Scenario 2: brightness=0 -> anode[i] high for 2 cycles per dwell (cycles 2-3 and 20-21); brightness=3 -> 8 cycles per dwell.
REQ-033 Scenario 3: brightness changed 7->0 at cycle 5 -> dwell 0 stays lit through cycle 17; dwell 1 is lit for cycles 20-21 only.
REQ-034 Scenario 4: two back-to-back load_valid frames, 8'h12 then 8'h34 -> first accepted; second held off (load_ready=0) until after the boundary, accepted then, and displayed one frame later; the 8'h12 value is never skipped.
REQ-035 Scenario 5: reset pulsed for one cycle at cycle 25 with a frame pending -> next cycle all outputs equal reset values; pending data is never displayed; frame_done does not pulse.
REQ-036 Scenario 6: run 5 frames -> frame_done pulses exactly at cycles 35, 71, 107, 143, 179; anode is never 2'b11.
